// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU function handler.
// Holds function codes, exception codes and the handler state encoding.
// No ports; imported by modbus_range_check and modbus_func_handler_gen.
package modbus_pkg;

  localparam logic [7:0] FC_RD_HOLD   = 8'h03;
  localparam logic [7:0] FC_RD_INPUT  = 8'h04;
  localparam logic [7:0] FC_WR_SINGLE = 8'h06;

  localparam logic [7:0] EXC_NONE      = 8'd0;
  localparam logic [7:0] EXC_ILL_FUNC  = 8'd1;
  localparam logic [7:0] EXC_ILL_ADDR  = 8'd2;
  localparam logic [7:0] EXC_ILL_VALUE = 8'd3;
  localparam logic [7:0] EXC_DEV_FAIL  = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_WRITE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/modbus_range_check.sv
// Combinational function-code / address / quantity validation.
// Ports: func, addr, qty in; exc (0 = ok), bank_input (1 = input bank),
// is_write (FC06) out. Sums are 17-bit so addr + qty cannot wrap.
module modbus_range_check
  import modbus_pkg::*;
#(
  parameter int          N_HOLD     = 4,
  parameter int          N_INPUT    = 4,
  parameter logic [15:0] HOLD_BASE  = 16'h0001,
  parameter logic [15:0] INPUT_BASE = 16'h0001,
  parameter int          MAX_QTY    = 16
) (
  input  logic [7:0]  func,
  input  logic [15:0] addr,
  input  logic [15:0] qty,
  output logic [7:0]  exc,
  output logic        bank_input,
  output logic        is_write
);

  logic [16:0] a17;
  logic [16:0] q17;
  logic [16:0] hold_lo;
  logic [16:0] hold_end;
  logic [16:0] in_lo;
  logic [16:0] in_end;

  assign a17      = {1'b0, addr};
  assign q17      = {1'b0, qty};
  assign hold_lo  = {1'b0, HOLD_BASE};
  assign hold_end = {1'b0, HOLD_BASE} + 17'(N_HOLD);
  assign in_lo    = {1'b0, INPUT_BASE};
  assign in_end   = {1'b0, INPUT_BASE} + 17'(N_INPUT);

  always_comb begin
    exc        = EXC_NONE;
    bank_input = 1'b0;
    is_write   = 1'b0;
    case (func)
      FC_RD_HOLD: begin
        if (q17 == 17'd0 || q17 > 17'(MAX_QTY))
          exc = EXC_ILL_VALUE;
        else if (a17 < hold_lo || a17 + q17 > hold_end)
          exc = EXC_ILL_ADDR;
      end
      FC_RD_INPUT: begin
        bank_input = 1'b1;
        if (q17 == 17'd0 || q17 > 17'(MAX_QTY))
          exc = EXC_ILL_VALUE;
        else if (a17 < in_lo || a17 + q17 > in_end)
          exc = EXC_ILL_ADDR;
      end
      FC_WR_SINGLE: begin
        is_write = 1'b1;
        if (a17 < hold_lo || a17 >= hold_end)
          exc = EXC_ILL_ADDR;
      end
      default: exc = EXC_ILL_FUNC;
    endcase
  end

endmodule

// File: rtl/modbus_func_handler_gen.sv
// Modbus RTU slave function handler: FC03/FC04 reads into TX RAM, FC06 writes.
// Ports: request in (rx_message_done/func_code/addr/data, exception_done/_in),
// register banks in, register write strobe + ack, TX RAM write port, result out.
module modbus_func_handler_gen
  import modbus_pkg::*;
#(
  parameter int          N_HOLD     = 4,
  parameter int          N_INPUT    = 4,
  parameter logic [15:0] HOLD_BASE  = 16'h0001,
  parameter logic [15:0] INPUT_BASE = 16'h0001,
  parameter int          MAX_QTY    = 16,
  parameter int          DP_AW      = 8,
  parameter int          WR_TIMEOUT = 1000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rx_message_done,
  input  logic [7:0]            func_code,
  input  logic [15:0]           addr,
  input  logic [15:0]           data,
  input  logic                  exception_done,
  input  logic [7:0]            exception_in,
  input  logic [16*N_HOLD-1:0]  hold_regs,
  input  logic [16*N_INPUT-1:0] input_regs,
  output logic                  reg_wen,
  output logic [5:0]            reg_waddr,
  output logic [15:0]           reg_wdat,
  input  logic                  reg_w_done,
  input  logic                  reg_w_status,
  output logic                  dpram_wen,
  output logic [DP_AW-1:0]      dpram_addr,
  output logic [15:0]           dpram_wdata,
  output logic [7:0]            tx_quantity,
  output logic [7:0]            exception_out,
  output logic [7:0]            func_code_r,
  output logic                  handler_done
);

  localparam int TW = $clog2(WR_TIMEOUT + 1);

  state_t        state;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic [6:0]    cnt;
  logic [TW-1:0] timer;

  logic [7:0]    chk_exc;
  logic          bank_input;
  logic          is_write;
  logic [15:0]   off;
  logic [15:0]   rd_idx;
  logic [15:0]   rd_word;

  modbus_range_check #(
    .N_HOLD     (N_HOLD),
    .N_INPUT    (N_INPUT),
    .HOLD_BASE  (HOLD_BASE),
    .INPUT_BASE (INPUT_BASE),
    .MAX_QTY    (MAX_QTY)
  ) u_range_check (
    .func       (func_code_r),
    .addr       (addr_q),
    .qty        (data_q),
    .exc        (chk_exc),
    .bank_input (bank_input),
    .is_write   (is_write)
  );

  // Offset of the first requested register within its bank; cnt walks the
  // request, so rd_idx is the word staged next into the TX RAM.
  assign off    = bank_input ? (addr_q - INPUT_BASE) : (addr_q - HOLD_BASE);
  assign rd_idx = off + {9'd0, cnt};

  // Mux by comparison so an out-of-range index can never select past the bank.
  always_comb begin
    rd_word = 16'd0;
    if (bank_input) begin
      for (int k = 0; k < N_INPUT; k++)
        if (rd_idx == 16'(k)) rd_word = input_regs[16*k +: 16];
    end else begin
      for (int k = 0; k < N_HOLD; k++)
        if (rd_idx == 16'(k)) rd_word = hold_regs[16*k +: 16];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_IDLE;
      addr_q        <= 16'd0;
      data_q        <= 16'd0;
      cnt           <= 7'd0;
      timer         <= '0;
      reg_wen       <= 1'b0;
      reg_waddr     <= 6'd0;
      reg_wdat      <= 16'd0;
      dpram_wen     <= 1'b0;
      dpram_addr    <= '0;
      dpram_wdata   <= 16'd0;
      tx_quantity   <= 8'd0;
      exception_out <= 8'd0;
      func_code_r   <= 8'd0;
      handler_done  <= 1'b0;
    end else begin
      reg_wen      <= 1'b0;
      handler_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_message_done) begin
            func_code_r <= func_code;
            addr_q      <= addr;
            data_q      <= data;
          end
          if (exception_done) begin
            cnt <= 7'd0;
            if (exception_in != 8'd0) begin
              exception_out <= exception_in;
              tx_quantity   <= 8'd0;
              handler_done  <= 1'b1;
              state         <= ST_DONE;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (chk_exc != EXC_NONE) begin
            exception_out <= chk_exc;
            tx_quantity   <= 8'd0;
            handler_done  <= 1'b1;
            state         <= ST_DONE;
          end else if (is_write) begin
            // Strobe is registered here so it is high in the WRITE cycle.
            reg_wen   <= 1'b1;
            reg_waddr <= off[5:0];
            reg_wdat  <= data_q;
            state     <= ST_WRITE;
          end else begin
            dpram_wen   <= 1'b1;
            dpram_addr  <= '0;
            dpram_wdata <= rd_word;
            cnt         <= 7'd1;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (cnt == data_q[6:0]) begin
            dpram_wen     <= 1'b0;
            tx_quantity   <= data_q[7:0];
            exception_out <= EXC_NONE;
            handler_done  <= 1'b1;
            state         <= ST_DONE;
          end else begin
            dpram_addr  <= DP_AW'(cnt);
            dpram_wdata <= rd_word;
            cnt         <= cnt + 7'd1;
          end
        end
        ST_WRITE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // An acknowledge in the timeout cycle still wins.
          if (reg_w_done) begin
            exception_out <= reg_w_status ? EXC_DEV_FAIL : EXC_NONE;
            tx_quantity   <= reg_w_status ? 8'd0 : 8'd1;
            handler_done  <= 1'b1;
            state         <= ST_DONE;
          end else if (timer == TW'(WR_TIMEOUT)) begin
            exception_out <= EXC_DEV_FAIL;
            tx_quantity   <= 8'd0;
            handler_done  <= 1'b1;
            state         <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_func_handler_gen.sv
module tb_modbus_func_handler_gen;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rx_message_done = 1'b0;
  logic [7:0]  func_code = 8'd0;
  logic [15:0] addr = 16'd0;
  logic [15:0] data = 16'd0;
  logic        exception_done = 1'b0;
  logic [7:0]  exception_in = 8'd0;
  logic [63:0] hold_regs = {16'h00D4, 16'h00C3, 16'h00B2, 16'h00A1};
  logic [63:0] input_regs = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
  logic        reg_wen;
  logic [5:0]  reg_waddr;
  logic [15:0] reg_wdat;
  logic        reg_w_done = 1'b0;
  logic        reg_w_status = 1'b0;
  logic        dpram_wen;
  logic [7:0]  dpram_addr;
  logic [15:0] dpram_wdata;
  logic [7:0]  tx_quantity;
  logic [7:0]  exception_out;
  logic [7:0]  func_code_r;
  logic        handler_done;

  int total = 0;
  int bad = 0;

  // Per-request observations
  int          n_wr, n_wen, n_done, done_k, wen_k;
  int          wr_k [0:63];
  logic [7:0]  wr_a [0:63];
  logic [15:0] wr_d [0:63];
  logic [5:0]  wa;
  logic [15:0] wd;

  always #5 clk_in = ~clk_in;

  modbus_func_handler_gen #(
    .N_HOLD(4), .N_INPUT(4), .HOLD_BASE(16'h0001), .INPUT_BASE(16'h0001),
    .MAX_QTY(16), .DP_AW(8), .WR_TIMEOUT(20)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .rx_message_done(rx_message_done), .func_code(func_code), .addr(addr), .data(data),
    .exception_done(exception_done), .exception_in(exception_in),
    .hold_regs(hold_regs), .input_regs(input_regs),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdat(reg_wdat),
    .reg_w_done(reg_w_done), .reg_w_status(reg_w_status),
    .dpram_wen(dpram_wen), .dpram_addr(dpram_addr), .dpram_wdata(dpram_wdata),
    .tx_quantity(tx_quantity), .exception_out(exception_out),
    .func_code_r(func_code_r), .handler_done(handler_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one request (rx_message_done + exception_done in the same cycle,
  // cycle 0) and records every output event by cycle index until two cycles
  // after handler_done, or a 60-cycle budget.
  task automatic run_req(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] exc, input bit ack_en, input int ack_dly,
                         input logic ack_st);
    n_wr = 0; n_wen = 0; n_done = 0; done_k = -1; wen_k = -1;
    @(negedge clk_in);
    func_code = fc; addr = a; data = d; exception_in = exc;
    rx_message_done = 1'b1; exception_done = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_in);
      if (dpram_wen && n_wr < 64) begin
        wr_k[n_wr] = k; wr_a[n_wr] = dpram_addr; wr_d[n_wr] = dpram_wdata; n_wr++;
      end
      if (reg_wen) begin
        n_wen++; wen_k = k; wa = reg_waddr; wd = reg_wdat;
      end
      if (handler_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      rx_message_done = 1'b0; exception_done = 1'b0; exception_in = 8'd0;
      reg_w_status = ack_st;
      reg_w_done = ack_en && wen_k >= 0 && k == wen_k + ack_dly;
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    reg_w_done = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int exp_k, input logic [7:0] exp_q,
                            input logic [7:0] exp_e);
    chk({tag, "_lat"}, done_k, exp_k);
    chk({tag, "_npulse"}, n_done, 1);
    chk({tag, "_txq"}, tx_quantity, exp_q);
    chk({tag, "_exc"}, exception_out, exp_e);
  endtask

  task automatic chk_reads(input string tag, input int qty, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] exp_w [0:3];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    chk({tag, "_nwr"}, n_wr, qty);
    for (int i = 0; i < qty && i < n_wr; i++) begin
      chk({tag, "_wcyc"}, wr_k[i], 2 + i);
      chk({tag, "_waddr"}, wr_a[i], i);
      chk({tag, "_wdat"}, wr_d[i], exp_w[i]);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_done", handler_done, 0);
    chk("rst_dwen", dpram_wen, 0);
    chk("rst_txq", tx_quantity, 0);
    chk("rst_exc", exception_out, 0);
    chk("rst_rwen", reg_wen, 0);
    chk("rst_fc", func_code_r, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // FC03 full bank read
    run_req(8'h03, 16'd1, 16'd4, 8'd0, 0, 0, 0);
    chk_result("rd4", 6, 8'd4, 8'd0);
    chk_reads("rd4", 4, 16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4);
    chk("rd4_fc", func_code_r, 8'h03);
    @(negedge clk_in);
    chk("rd4_hold_txq", tx_quantity, 8'd4);

    // FC03 read ending exactly at the top of the bank
    run_req(8'h03, 16'd2, 16'd3, 8'd0, 0, 0, 0);
    chk_result("rdtop", 5, 8'd3, 8'd0);
    chk_reads("rdtop", 3, 16'h00B2, 16'h00C3, 16'h00D4, 16'h0000);

    // FC04 input bank read
    run_req(8'h04, 16'd1, 16'd2, 8'd0, 0, 0, 0);
    chk_result("in2", 4, 8'd2, 8'd0);
    chk_reads("in2", 2, 16'h0011, 16'h0022, 16'h0000, 16'h0000);

    // FC04 running one past the bank
    run_req(8'h04, 16'd3, 16'd3, 8'd0, 0, 0, 0);
    chk_result("in_oob", 2, 8'd0, 8'd2);
    chk("in_oob_nwr", n_wr, 0);

    // Quantity checks and unsupported function
    run_req(8'h03, 16'd1, 16'd0, 8'd0, 0, 0, 0);
    chk_result("q0", 2, 8'd0, 8'd3);
    run_req(8'h03, 16'd1, 16'd17, 8'd0, 0, 0, 0);
    chk_result("q17", 2, 8'd0, 8'd3);
    run_req(8'h03, 16'd1, 16'd16, 8'd0, 0, 0, 0);
    chk_result("q16", 2, 8'd0, 8'd2);
    run_req(8'h03, 16'd0, 16'd1, 8'd0, 0, 0, 0);
    chk_result("a0", 2, 8'd0, 8'd2);
    run_req(8'h10, 16'd1, 16'd1, 8'd0, 0, 0, 0);
    chk_result("fc10", 2, 8'd0, 8'd1);
    chk("fc10_fc", func_code_r, 8'h10);

    // FC06 success, ack 5 cycles after the strobe
    run_req(8'h06, 16'd2, 16'hBEEF, 8'd0, 1, 5, 1'b0);
    chk_result("wr_ok", 8, 8'd1, 8'd0);
    chk("wr_ok_nwen", n_wen, 1);
    chk("wr_ok_wencyc", wen_k, 2);
    chk("wr_ok_waddr", wa, 6'd1);
    chk("wr_ok_wdat", wd, 16'hBEEF);

    // Late acknowledge while idle must be ignored
    @(negedge clk_in);
    reg_w_done = 1'b1;
    @(negedge clk_in);
    reg_w_done = 1'b0;
    n_done = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (handler_done) n_done++;
    end
    chk("late_ack", n_done, 0);

    // FC06 with failed write
    run_req(8'h06, 16'd2, 16'hBEEF, 8'd0, 1, 5, 1'b1);
    chk_result("wr_fail", 8, 8'd0, 8'd4);
    chk("wr_fail_nwen", n_wen, 1);

    // FC06 address past the bank
    run_req(8'h06, 16'd5, 16'h1234, 8'd0, 0, 0, 0);
    chk_result("wr_oob", 2, 8'd0, 8'd2);
    chk("wr_oob_nwen", n_wen, 0);

    // FC06 timeout: done 22 cycles after the strobe
    run_req(8'h06, 16'd4, 16'h5555, 8'd0, 0, 0, 0);
    chk_result("wr_to", 24, 8'd0, 8'd4);
    chk("wr_to_wencyc", wen_k, 2);
    chk("wr_to_waddr", wa, 6'd3);

    // Upstream exception
    run_req(8'h03, 16'd1, 16'd4, 8'd2, 0, 0, 0);
    chk_result("up_exc", 1, 8'd0, 8'd2);
    chk("up_exc_nwr", n_wr, 0);

    // Reset in the middle of a read
    @(negedge clk_in);
    func_code = 8'h03; addr = 16'd1; data = 16'd4; exception_in = 8'd0;
    rx_message_done = 1'b1; exception_done = 1'b1;
    @(negedge clk_in);
    rx_message_done = 1'b0; exception_done = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("mid_inread", dpram_wen, 1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_dwen", dpram_wen, 0);
    chk("mid_daddr", dpram_addr, 0);
    chk("mid_ddat", dpram_wdata, 0);
    chk("mid_txq", tx_quantity, 0);
    chk("mid_fc", func_code_r, 0);
    n_done = 0;
    repeat (4) begin
      @(negedge clk_in);
      if (handler_done) n_done++;
    end
    rst_n_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      if (handler_done) n_done++;
    end
    chk("mid_nodone", n_done, 0);
    run_req(8'h03, 16'd1, 16'd4, 8'd0, 0, 0, 0);
    chk_result("after_rst", 6, 8'd4, 8'd0);
    chk_reads("after_rst", 4, 16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
